// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for an 8-bit Fibonacci LFSR word stream.
// It hunts for lock by predicting each word from the previous one. Once locked,
// it compares every valid word against a free-running reference and counts
// mismatched words in a saturating error counter.
module lfsr_checker #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 4,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]       LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_TH = 4'(UNLOCK_CNT);
    localparam logic [3:0]       NIB_ONE   = 4'd1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W    = '0;

    // Successor of an LFSR word: shift left, feedback parity into the LSB.
    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ^(w & TAPS)};
    endfunction

    state_t           state_q, state_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       bad_cnt_q, bad_cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] ref_q, ref_d;

    logic [WIDTH-1:0] pred_w;
    logic [WIDTH-1:0] exp_w;
    logic [3:0]       match_inc;
    logic [3:0]       bad_inc;

    // Predictions for both modes; only one is consumed per cycle.
    always_comb begin
        pred_w    = next_word(prev_q);
        exp_w     = next_word(ref_q);
        match_inc = match_cnt_q + NIB_ONE;
        bad_inc   = bad_cnt_q + NIB_ONE;
    end

    // Next-state and output computation for the hunt/locked FSM.
    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        have_prev_d = have_prev_q;
        match_cnt_d = match_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        prev_d      = prev_q;
        ref_d       = ref_q;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    prev_d      = in_data;
                    have_prev_d = 1'b1;
                    // All-zero is the lockup state and never a legal word.
                    if (have_prev_q && (in_data == pred_w) && (in_data != ZERO_W)) begin
                        if (match_inc == LOCK_TH) begin
                            state_d     = LOCKED;
                            locked_d    = 1'b1;
                            ref_d       = in_data;
                            bad_cnt_d   = '0;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Reference free-runs so one corrupted word costs one error.
                    ref_d = exp_w;
                    if (in_data == exp_w) begin
                        bad_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                        if (bad_inc == UNLOCK_TH) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            match_cnt_d = '0;
                            bad_cnt_d   = '0;
                            have_prev_d = 1'b1;
                            prev_d      = in_data;
                        end else begin
                            bad_cnt_d = bad_inc;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clearing takes priority over a coincident increment.
        if (clear_cnt) begin
            err_cnt_d = '0;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            have_prev_q <= 1'b0;
            match_cnt_q <= '0;
            bad_cnt_q   <= '0;
            prev_q      <= '0;
            ref_q       <= '0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            have_prev_q <= have_prev_d;
            match_cnt_q <= match_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            prev_q      <= prev_d;
            ref_q       <= ref_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them one cycle later.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clear_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;

    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_clear;
    logic        s_locked;
    logic        s_err;
    logic [3:0]  s_cnt;

    int unsigned cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    int          vid = 0;

    typedef struct {
        int unsigned cyc;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    lfsr_checker #(
        .WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    // Narrow counter and high unlock threshold so saturation is reachable quickly.
    lfsr_checker #(
        .WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_W(4)
    ) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
        .clear_cnt(s_clear), .locked(s_locked), .err(s_err), .err_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: an expectation issued in cycle c is due at the negedge after edge c+1.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            nvec++;
            if (locked !== mon_e.lk || err !== mon_e.er || err_cnt !== mon_e.cnt) begin
                nfail++;
                $display("FAIL vec%0d: got locked=%b err=%b err_cnt=%h, want locked=%b err=%b err_cnt=%h",
                         mon_e.id, locked, err, err_cnt, mon_e.lk, mon_e.er, mon_e.cnt);
            end
        end
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] w);
        return {w[6:0], ^(w & 8'hB8)};
    endfunction

    task automatic push(input logic lk, input logic er, input logic [15:0] cnt);
        sb.push_back('{cyc, lk, er, cnt, vid});
        vid++;
    endtask

    task automatic send(input logic [7:0] d, input logic clr,
                        input logic lk, input logic er, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        clear_cnt = clr;
        push(lk, er, cnt);
    endtask

    task automatic idle(input logic lk, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        clear_cnt = 1'b0;
        push(lk, 1'b0, cnt);
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_cnt = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic direct_check(input string nm, input logic lk, input logic er,
                                input logic [15:0] cnt);
        nvec++;
        if (locked !== lk || err !== er || err_cnt !== cnt) begin
            nfail++;
            $display("FAIL %s: got locked=%b err=%b err_cnt=%h, want locked=%b err=%b err_cnt=%h",
                     nm, locked, err, err_cnt, lk, er, cnt);
        end
    endtask

    task automatic do_reset();
        drain();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends one word to the saturation instance and checks it directly.
    task automatic sat_send(input logic [7:0] d, input logic clr,
                            input logic lk, input logic er, input logic [3:0] cnt);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = d;
        s_clear = clr;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_clear = 1'b0;
        nvec++;
        if (s_locked !== lk || s_err !== er || s_cnt !== cnt) begin
            nfail++;
            $display("FAIL sat d=%h: got locked=%b err=%b cnt=%h, want locked=%b err=%b cnt=%h",
                     d, s_locked, s_err, s_cnt, lk, er, cnt);
        end
    endtask

    logic [7:0] r;
    logic [3:0] sc;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; clear_cnt = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        direct_check("reset_state", 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Lock on 01,02,04,08,11: the fifth word completes four matches.
        send(8'h01, 0, 0, 0, 16'd0);
        send(8'h02, 0, 0, 0, 16'd0);
        send(8'h04, 0, 0, 0, 16'd0);
        send(8'h08, 0, 0, 0, 16'd0);
        send(8'h11, 0, 1, 0, 16'd0);

        // Idle does not advance the reference; FF replaces expected 8E.
        idle(1, 16'd0);
        send(8'h23, 0, 1, 0, 16'd0);
        send(8'h47, 0, 1, 0, 16'd0);
        send(8'hFF, 0, 1, 1, 16'd1);
        idle(1, 16'd1);
        send(8'h1C, 0, 1, 0, 16'd1);

        // Four zero words (expected 38,71,E2,C4) drop lock on the fourth.
        send(8'h00, 0, 1, 1, 16'd2);
        send(8'h00, 0, 1, 1, 16'd3);
        send(8'h00, 0, 1, 1, 16'd4);
        send(8'h00, 0, 0, 1, 16'd5);
        // prev is 00 after unlock, so 01 is a non-match seed and 11 relocks.
        send(8'h01, 0, 0, 0, 16'd5);
        send(8'h02, 0, 0, 0, 16'd5);
        send(8'h04, 0, 0, 0, 16'd5);
        send(8'h08, 0, 0, 0, 16'd5);
        send(8'h11, 0, 1, 0, 16'd5);

        // Clear coinciding with an error (expected 47) leaves zero.
        send(8'h23, 0, 1, 0, 16'd5);
        send(8'h00, 1, 1, 1, 16'd0);
        send(8'h8E, 0, 1, 0, 16'd0);

        // Build err_cnt=3 while staying locked (expected 1C,38,71,E2,C4).
        send(8'h00, 0, 1, 1, 16'd1);
        send(8'h38, 0, 1, 0, 16'd1);
        send(8'h00, 0, 1, 1, 16'd2);
        send(8'hE2, 0, 1, 0, 16'd2);
        send(8'h00, 0, 1, 1, 16'd3);
        drain();

        // Asynchronous reset between edges takes effect immediately.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        direct_check("async_reset", 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        send(8'h01, 0, 0, 0, 16'd0);
        send(8'h02, 0, 0, 0, 16'd0);
        send(8'h04, 0, 0, 0, 16'd0);
        send(8'h08, 0, 0, 0, 16'd0);
        send(8'h11, 0, 1, 0, 16'd0);

        // Gaps in hunt mode are ignored.
        do_reset();
        send(8'h01, 0, 0, 0, 16'd0);
        idle(0, 16'd0);
        idle(0, 16'd0);
        idle(0, 16'd0);
        send(8'h02, 0, 0, 0, 16'd0);
        send(8'h04, 0, 0, 0, 16'd0);
        send(8'h08, 0, 0, 0, 16'd0);
        send(8'h11, 0, 1, 0, 16'd0);

        // Repeated zero words never lock.
        do_reset();
        for (int i = 0; i < 8; i++) send(8'h00, 0, 0, 0, 16'd0);
        send(8'h01, 0, 0, 0, 16'd0);
        send(8'h02, 0, 0, 0, 16'd0);
        send(8'h04, 0, 0, 0, 16'd0);
        send(8'h08, 0, 0, 0, 16'd0);
        send(8'h11, 0, 1, 0, 16'd0);
        do_reset();

        // Saturation on the 4-bit instance.
        sat_send(8'h01, 0, 0, 0, 4'd0);
        sat_send(8'h02, 0, 0, 0, 4'd0);
        sat_send(8'h04, 0, 0, 0, 4'd0);
        sat_send(8'h08, 0, 0, 0, 4'd0);
        sat_send(8'h11, 0, 1, 0, 4'd0);
        r = 8'h11;
        for (int k = 1; k <= 14; k++) begin
            r = lfsr_next(r);
            sc = 4'(k);
            sat_send(8'h00, 0, 1, 1, sc);
        end
        r = lfsr_next(r);
        sat_send(r, 0, 1, 0, 4'd14);
        sat_send(8'h00, 0, 1, 1, 4'd15);
        r = lfsr_next(r);
        for (int k = 0; k < 13; k++) begin
            r = lfsr_next(r);
            sat_send(8'h00, 0, 1, 1, 4'd15);
        end
        r = lfsr_next(r);
        sat_send(r, 0, 1, 0, 4'd15);
        r = lfsr_next(r);
        sat_send(8'h00, 1, 1, 1, 4'd0);
        r = lfsr_next(r);
        sat_send(r, 0, 1, 0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
